// File: rtl/clock_gen_bank.sv
// Bank of NUM_CH independent programmable clock dividers with boundary-safe ratio updates.
// Optional macro CLOCK_GEN_BANK_STROBE_EN enables the rise_stb/fall_stb edge strobes.
module clock_gen_bank #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned CH_W         = 1,
    parameter int unsigned HALF_DEFAULT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_stb,
    output logic [NUM_CH-1:0] fall_stb
);

    logic [NUM_CH-1:0][CNT_W-1:0] half_q, half_d;
    logic [NUM_CH-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            pend_v_q, pend_v_d;
    logic [NUM_CH-1:0]            out_q, out_d;

    logic             cfg_hit;
    logic [CNT_W-1:0] cfg_val;

    assign cfg_hit = cfg_we && (32'(cfg_ch) < NUM_CH);
    // A zero half-period would never terminate a phase; treat it as the fastest ratio.
    assign cfg_val = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    always_comb begin
        half_d   = half_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sync || !ch_en[i]) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
                if (pend_v_q[i]) begin
                    half_d[i]   = pend_q[i];
                    pend_v_d[i] = 1'b0;
                end
            end else if (cnt_q[i] == half_q[i] - CNT_W'(1)) begin
                cnt_d[i] = '0;
                out_d[i] = ~out_q[i];
                // Only the high-to-low toggle is a safe point to switch ratio.
                if (out_q[i] && pend_v_q[i]) begin
                    half_d[i]   = pend_q[i];
                    pend_v_d[i] = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            // Write lands after any apply, so a same-edge write waits for the next boundary.
            if (cfg_hit && (cfg_ch == CH_W'(i))) begin
                pend_d[i]   = cfg_val;
                pend_v_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q   <= {NUM_CH{CNT_W'(HALF_DEFAULT)}};
            pend_q   <= '0;
            pend_v_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            half_q   <= half_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign clk_out = out_q;

`ifdef CLOCK_GEN_BANK_STROBE_EN
    logic [NUM_CH-1:0] rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
`else
    assign rise_stb = '0;
    assign fall_stb = '0;
`endif

endmodule

// File: tb/tb_clock_gen_bank.sv
// Directed plus randomized bench for clock_gen_bank against a period-position reference model.
module tb_clock_gen_bank;

    localparam int NUM_CH       = 2;
    localparam int CNT_W        = 8;
    localparam int CH_W         = 2;
    localparam int HALF_DEFAULT = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] rise_stb;
    logic [NUM_CH-1:0] fall_stb;

    clock_gen_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .CH_W        (CH_W),
        .HALF_DEFAULT(HALF_DEFAULT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ch_en   (ch_en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_half(cfg_half),
        .clk_out (clk_out),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb)
    );

    always #5 clk = ~clk;

    // Reference: position within the current period (0..2H-1); output is high in the second half.
    int m_half [NUM_CH];
    int m_pend [NUM_CH];
    int m_pos  [NUM_CH];
    bit m_pv   [NUM_CH];
    bit m_out  [NUM_CH];
    bit m_rise [NUM_CH];
    bit m_fall [NUM_CH];

    int errors = 0;
    int checks = 0;

    task automatic model_edge();
        bit prev;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                m_half[c] = HALF_DEFAULT;
                m_pv[c]   = 1'b0;
                m_pos[c]  = 0;
                m_out[c]  = 1'b0;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
            end else begin
                prev = m_out[c];
                if (sync || !ch_en[c]) begin
                    m_pos[c] = 0;
                    if (m_pv[c]) begin
                        m_half[c] = m_pend[c];
                        m_pv[c]   = 1'b0;
                    end
                end else begin
                    m_pos[c] = (m_pos[c] + 1) % (2 * m_half[c]);
                    if (m_pos[c] == 0 && m_pv[c]) begin
                        m_half[c] = m_pend[c];
                        m_pv[c]   = 1'b0;
                    end
                end
                m_out[c] = (sync || !ch_en[c]) ? 1'b0 : (m_pos[c] >= m_half[c]);
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_pend[c] = (cfg_half == 0) ? 1 : int'(cfg_half);
                    m_pv[c]   = 1'b1;
                end
`ifdef CLOCK_GEN_BANK_STROBE_EN
                m_rise[c] = m_out[c] && !prev;
                m_fall[c] = !m_out[c] && prev;
`else
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM_CH-1:0] eo, er, ef;
        for (int c = 0; c < NUM_CH; c++) begin
            eo[c] = m_out[c];
            er[c] = m_rise[c];
            ef[c] = m_fall[c];
        end
        checks++;
        assert (clk_out === eo) else begin
            errors++;
            $error("FAIL %s clk_out: got %b expected %b", tag, clk_out, eo);
        end
        checks++;
        assert (rise_stb === er) else begin
            errors++;
            $error("FAIL %s rise_stb: got %b expected %b", tag, rise_stb, er);
        end
        checks++;
        assert (fall_stb === ef) else begin
            errors++;
            $error("FAIL %s fall_stb: got %b expected %b", tag, fall_stb, ef);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic write_cfg(input string tag, input int ch, input int h);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_half = CNT_W'(h);
        step(tag);
        cfg_we   = 1'b0;
    endtask

    initial begin
        int guard;
        rst      = 1'b1;
        ch_en    = '1;
        sync     = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_half = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = 0;
            m_half[c] = HALF_DEFAULT;
        end
        run("reset", 2);
        rst = 1'b0;

        // Defaults: rise at edge 5, fall at edge 10.
        run("default", 25);

        // Mid-high-phase ratio change on ch1.
        write_cfg("cfg_mid", 1, 2);
        run("ratio_change", 20);

        write_cfg("cfg_zero", 0, 0);
        run("half_zero", 10);
        write_cfg("cfg_bad_ch", 3, 9);
        run("bad_ch", 10);
        write_cfg("cfg_first", 1, 3);
        write_cfg("cfg_second", 1, 7);
        run("double_write", 30);

        // Disable ch0 while high, then re-enable.
        write_cfg("cfg_en", 0, 4);
        guard = 0;
        while (!(m_out[0] && m_half[0] == 4) && guard < 60) begin
            step("wait_high");
            guard++;
        end
        checks++;
        assert (guard < 60) else begin
            errors++;
            $error("FAIL wait_high timeout: got %0d expected <60", guard);
        end
        ch_en[0] = 1'b0;
        run("disable", 4);
        ch_en[0] = 1'b1;
        run("reenable", 20);

        // Sync re-alignment with halves 3 and 6.
        write_cfg("cfg_s0", 0, 3);
        write_cfg("cfg_s1", 1, 6);
        run("free_run", 31);
        sync = 1'b1;
        step("sync");
        sync = 1'b0;
        run("post_sync", 40);

        // Reset mid-period discards a pending write.
        write_cfg("cfg_pre_rst", 0, 2);
        rst = 1'b1;
        step("mid_reset");
        rst = 1'b0;
        run("after_reset", 15);

        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(199) == 0);
            sync     = ($urandom_range(49) == 0);
            for (int c = 0; c < NUM_CH; c++) ch_en[c] = ($urandom_range(7) != 0);
            cfg_we   = ($urandom_range(7) == 0);
            cfg_ch   = CH_W'($urandom_range(3));
            cfg_half = CNT_W'($urandom_range(7));
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
